nios_pio_poller: RTL

//  Avalon-MM read master that periodically polls the data register of an input PIO slave.
//  It is the initiator for an in-port PIO s1 interface, so fabric logic can react to
//  pin changes without the CPU.

---
 rtl/nios_pio_poller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/nios_pio_poller.sv
// -----------------------------------------------------------------------------
// nios_pio_poller
//
// Avalon-MM read master that polls the data register of an input PIO slave at a
// fixed interval. The captured pins are published to fabric logic together with
// a sticky valid flag and single-cycle change / rise / fall strobes, so logic can
// react to pin changes without involving the CPU.
//
// Ports
//   clk            in   1        clock
//   reset_n        in   1        asynchronous, active-low reset
//   enable         in   1        1 = polling runs; 0 = timer held at 0, no new polls
//   m_address      out  ADDR_W   Avalon address (POLL_ADDR while m_read=1, else 0)
//   m_read         out  1        Avalon read request
//   m_waitrequest  in   1        Avalon waitrequest (tie to 0 if the slave lacks it)
//   m_readdata     in   32       Avalon read data
//   value          out  DATA_W   last captured readdata[DATA_W-1:0]
//   value_valid    out  1        sticky, set by the first completed poll
//   changed        out  1        1-cycle pulse: new sample differs from previous
//   rise           out  DATA_W   1-cycle per-bit pulse on 0->1
//   fall           out  DATA_W   1-cycle per-bit pulse on 1->0
//
// Parameters
//   DATA_W        tracked low bits of readdata
//   ADDR_W        address width
//   POLL_ADDR     register address read on every poll
//   POLL_DIV      clk cycles between poll starts (>= 2)
//   READ_LATENCY  fixed slave read latency in cycles (0..3)
// -----------------------------------------------------------------------------
module nios_pio_poller #(
    parameter int DATA_W       = 1,
    parameter int ADDR_W       = 2,
    parameter int POLL_ADDR    = 0,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              changed,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall
);

    localparam int TIMER_W = $clog2(POLL_DIV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
    localparam logic [ADDR_W-1:0]  ADDR_POLL  = ADDR_W'(POLL_ADDR);
    // Latency countdown is loaded with READ_LATENCY-1 so that the LAT cycle in
    // which it reads zero is exactly cycle T+READ_LATENCY.
    localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LAT  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [1:0]         lat_cnt_reg;
    logic               pending_reg;

    logic               poll_req;
    logic               start_poll;
    logic               sample_fire;
    logic [DATA_W-1:0]  sample_bits;
    logic [DATA_W-1:0]  rise_next;
    logic [DATA_W-1:0]  fall_next;

    // Terminal count of the free-running timer is the poll request.
    assign poll_req = enable && (timer_reg == TIMER_LAST);

    // In IDLE a direct request or a held one starts a read. Disabling clears
    // the held request, so it is gated by enable as well.
    assign start_poll = (state_reg == ST_IDLE) && (poll_req || (enable && pending_reg));

    // Read data is valid either in the accept cycle (zero latency) or in the
    // last LAT cycle.
    assign sample_fire = ((READ_LATENCY == 0) && (state_reg == ST_REQ) && !m_waitrequest) ||
                         ((state_reg == ST_LAT) && (lat_cnt_reg == 2'd0));

    assign sample_bits = m_readdata[DATA_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_edge
            assign rise_next[gi] =  sample_bits[gi] & ~value[gi];
            assign fall_next[gi] = ~sample_bits[gi] &  value[gi];
        end

        // Upper readdata bits are intentionally not tracked.
        if (DATA_W < 32) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^m_readdata[31:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            lat_cnt_reg <= 2'd0;
            pending_reg <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            changed     <= 1'b0;
            rise        <= '0;
            fall        <= '0;
        end else begin
            // Poll interval timer: held at zero while disabled, wraps at POLL_DIV-1.
            if (!enable) begin
                timer_reg <= '0;
            end else if (timer_reg == TIMER_LAST) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + 1'b1;
            end

            // At most one request is remembered while a read is in flight;
            // extra requests collapse into it. Any pending request is consumed
            // by IDLE (it always starts a read there).
            if (!enable) begin
                pending_reg <= 1'b0;
            end else if (state_reg != ST_IDLE) begin
                if (poll_req) begin
                    pending_reg <= 1'b1;
                end
            end else begin
                pending_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_poll) begin
                        state_reg <= ST_REQ;
                        m_read    <= 1'b1;
                        m_address <= ADDR_POLL;
                    end
                end

                // The request is held untouched until the slave accepts it,
                // even if enable drops meanwhile.
                ST_REQ: begin
                    if (!m_waitrequest) begin
                        m_read    <= 1'b0;
                        m_address <= '0;
                        if (READ_LATENCY == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_LAT;
                            lat_cnt_reg <= LAT_LOAD;
                        end
                    end
                end

                ST_LAT: begin
                    if (lat_cnt_reg == 2'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    m_read    <= 1'b0;
                    m_address <= '0;
                end
            endcase

            // Strobes are single-cycle by default.
            changed <= 1'b0;
            rise    <= '0;
            fall    <= '0;

            if (sample_fire) begin
                value       <= sample_bits;
                value_valid <= 1'b1;
                // No previous sample exists before the first capture, so the
                // first one after reset never produces edge pulses.
                if (value_valid) begin
                    changed <= (sample_bits != value);
                    rise    <= rise_next;
                    fall    <= fall_next;
                end
            end
        end
    end

endmodule
